comparador_palavras_sequencial: RTL and testbench
=================================================

COMPARADOR_PALAVRAS_SEQUENCIAL -- requirements
Module: comparador_palavras_sequencial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, meaning operand width in bits (legal range 1..32).
REQ-002 The block SHALL have parameter LOCK_COUNT, default 4, meaning consecutive passing compares needed to assert locked (legal range 1..255).
REQ-003 The block SHALL have parameter CNT_WIDTH, default 8, meaning match_count width.
REQ-004 Ports SHALL be: clk in 1 system clock; rst_n in 1 asynchronous active-low reset; in_valid in 1 operand pair offered; in_ready out 1 block accepts pair; a in WIDTH operand A; b in WIDTH operand B; mode in 2 compare mode; clear in 1 synchronous FSM/counter clear; out_valid out 1 result held; out_ready in 1 consumer accepts result; fi out 1 mode-selected result; eq out 1 a==b; gt out 1 a>b; lt out 1 a<b; locked out 1 lock-run reached; match_count out CNT_WIDTH passing-compare count (macro only).
REQ-005 The design SHALL use one clock, clk; reset rst_n SHALL be asynchronous and active-low.

Function
REQ-006 A transfer SHALL occur on a rising clk edge when in_valid=1 and in_ready=1.
REQ-007 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-008 Results of a transfer SHALL appear registered one cycle later with out_valid=1 (latency 1).
REQ-009 eq/gt/lt SHALL be unsigned comparisons of a and b; exactly one SHALL be 1 while out_valid=1.
REQ-010 fi SHALL be: mode 00 eq; 01 gt; 10 lt; 11 !eq.
REQ-011 While out_valid=1 and out_ready=0, fi, eq, gt, lt SHALL hold stable and no transfer SHALL occur.
REQ-012 out_valid SHALL clear after an out_ready=1 edge with no simultaneous transfer; with a simultaneous transfer, new results SHALL replace old ones with out_valid kept at 1 (full throughput).
REQ-013 Run FSM states SHALL be IDLE (run=0), COUNTING (0<run<LOCK_COUNT), LOCKED (locked=1).
REQ-014 On each transfer with passing fi, run SHALL increment; on reaching LOCK_COUNT the FSM SHALL enter LOCKED; passing compares in LOCKED SHALL keep LOCKED.
REQ-015 A transfer with failing fi SHALL return the FSM to IDLE from any state with run=0.
REQ-016 FSM state and locked SHALL update on the same edge as the results of the causing transfer.
REQ-017 clear=1 SHALL force IDLE, run=0 and match_count=0 on the next edge, overriding any simultaneous transfer's effect on FSM/counter; the transfer's results SHALL still be produced.
REQ-018 With LOCK_COUNT=1, a single passing transfer SHALL enter LOCKED directly from IDLE.

Reset
REQ-019 rst_n=0 SHALL immediately force out_valid=0, fi=0, eq=0, gt=0, lt=0, locked=0, match_count=0, FSM IDLE, run=0.
REQ-020 in_ready SHALL be 1 during and after reset; reset mid-transfer SHALL discard the pending result.

Configuration
REQ-021 With macro COMPARADOR_MATCH_COUNT_EN defined, match_count SHALL exist and increment by 1 per passing transfer, saturating at 2^CNT_WIDTH-1.
REQ-022 Without COMPARADOR_MATCH_COUNT_EN, port match_count and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-023 Reset then mode=00, a=5,b=5 transfer -> next cycle out_valid=1, fi=1, eq=1, gt=0, lt=0.
REQ-024 mode=01, a=6,b=2 with out_ready=0 for 3 cycles -> fi=1, gt=1 held, in_ready=0, second offered pair not accepted until out_ready=1.
REQ-025 LOCK_COUNT=4, four back-to-back equal pairs (3,3) with out_ready=1 -> locked=1 on 4th result cycle; fifth pair (3,4) -> locked=0, FSM IDLE.
REQ-026 Three passing transfers, then clear=1 coincident with fourth passing transfer -> locked stays 0, match_count=0, fourth result still fi=1.
REQ-027 With COMPARADOR_MATCH_COUNT_EN, CNT_WIDTH=2, five passing transfers -> match_count=3 (saturated).
REQ-028 rst_n=0 asserted asynchronously while out_valid=1, locked=1 -> all outputs 0 before the next clk edge, in_ready=1.

Source files
------------

// File: rtl/comparador_palavras_sequencial.sv
// Sequential word comparator: one-deep valid/ready result stage plus a lock-run FSM.
// Optional passing-compare counter on port match_count when COMPARADOR_MATCH_COUNT_EN is defined.
module comparador_palavras_sequencial #(
  parameter int WIDTH      = 3,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             fi,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic             locked
`ifdef COMPARADOR_MATCH_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] match_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COUNTING = 2'd1,
    S_LOCKED   = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_run;
  logic        r_out_valid;
  logic        r_fi;
  logic        r_eq;
  logic        r_gt;
  logic        r_lt;
  logic        r_locked;

  logic        w_xfer;
  logic        w_eq;
  logic        w_gt;
  logic        w_lt;
  logic        w_pass;
  logic [8:0]  w_run_inc;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_xfer    = in_valid && in_ready;
  assign w_eq      = (a == b);
  assign w_gt      = (a > b);
  assign w_lt      = (a < b);
  assign w_run_inc = {1'b0, r_run} + 9'd1;

  always_comb begin
    w_pass = 1'b0;
    case (mode)
      2'b00:   w_pass = w_eq;
      2'b01:   w_pass = w_gt;
      2'b10:   w_pass = w_lt;
      default: w_pass = !w_eq;
    endcase
  end

  // Result stage: a new transfer always overwrites, so a consumed result can be replaced in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_fi        <= 1'b0;
      r_eq        <= 1'b0;
      r_gt        <= 1'b0;
      r_lt        <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_fi        <= w_pass;
      r_eq        <= w_eq;
      r_gt        <= w_gt;
      r_lt        <= w_lt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Lock-run FSM; clear wins over whatever the coincident transfer would have done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_run    <= 8'd0;
      r_locked <= 1'b0;
    end else if (clear) begin
      r_state  <= S_IDLE;
      r_run    <= 8'd0;
      r_locked <= 1'b0;
    end else if (w_xfer) begin
      if (!w_pass) begin
        r_state  <= S_IDLE;
        r_run    <= 8'd0;
        r_locked <= 1'b0;
      end else if (r_state != S_LOCKED) begin
        if (w_run_inc >= 9'(LOCK_COUNT)) begin
          r_state  <= S_LOCKED;
          r_run    <= 8'(LOCK_COUNT);
          r_locked <= 1'b1;
        end else begin
          r_state  <= S_COUNTING;
          r_run    <= w_run_inc[7:0];
          r_locked <= 1'b0;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign fi        = r_fi;
  assign eq        = r_eq;
  assign gt        = r_gt;
  assign lt        = r_lt;
  assign locked    = r_locked;

`ifdef COMPARADOR_MATCH_COUNT_EN
  logic [CNT_WIDTH-1:0] r_match_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match_count <= '0;
    end else if (clear) begin
      r_match_count <= '0;
    end else if (w_xfer && w_pass && (r_match_count != {CNT_WIDTH{1'b1}})) begin
      r_match_count <= r_match_count + 1'b1;
    end
  end

  assign match_count = r_match_count;
`else
  logic w_unused_cnt_width;
  assign w_unused_cnt_width = (CNT_WIDTH > 0);
`endif

endmodule

// File: tb/tb_comparador_palavras_sequencial.sv
// Scoreboard bench for comparador_palavras_sequencial: directed scenarios plus random traffic.
// Compile with COMPARADOR_MATCH_COUNT_EN defined to also check match_count.
module tb_comparador_palavras_sequencial;

  localparam int W    = 3;
  localparam int LC   = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [1:0]    mode = 2'b00;
  logic          clear = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          fi, eq, gt, lt, locked;
`ifdef COMPARADOR_MATCH_COUNT_EN
  logic [CW-1:0] match_count;
`endif

  comparador_palavras_sequencial #(.WIDTH(W), .LOCK_COUNT(LC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .fi(fi), .eq(eq), .gt(gt), .lt(lt), .locked(locked)
`ifdef COMPARADOR_MATCH_COUNT_EN
    , .match_count(match_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic fi; logic eq; logic gt; logic lt; logic locked; int cnt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_run  = 0;
  int   m_cnt  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: compare rule from the mode table, run length as a plain integer.
  task automatic model_xfer(input int ia, input int ib, input int m, input bit clr);
    exp_t e;
    bit   p;
    case (m)
      0: p = (ia == ib);
      1: p = (ia > ib);
      2: p = (ia < ib);
      default: p = (ia != ib);
    endcase
    if (clr) begin
      m_run = 0; m_cnt = 0;
    end else if (p) begin
      m_run = m_run + 1;
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    end else begin
      m_run = 0;
    end
    e.fi = p; e.eq = (ia == ib); e.gt = (ia > ib); e.lt = (ia < ib);
    e.locked = (m_run >= LC); e.cnt = m_cnt;
    q.push_back(e);
    $display("xfer a=%0d b=%0d mode=%0d clear=%0d -> fi=%0d locked=%0d", ia, ib, m, clr, p, e.locked);
  endtask

  // One cycle of stimulus, entered and left at posedge+1.
  task automatic cycle(input bit v, input int ia, input int ib, input int m, input bit ordy, input bit clr);
    in_valid = v; a = W'(ia); b = W'(ib); mode = 2'(m); out_ready = ordy; clear = clr;
    @(negedge clk);
    if (v && in_ready) model_xfer(ia, ib, m, clr);
    else clear = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    q.delete(); m_run = 0; m_cnt = 0;
    in_valid = 0; clear = 0; out_ready = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("fi", fi, e.fi);
        chk("eq", eq, e.eq);
        chk("gt", gt, e.gt);
        chk("lt", lt, e.lt);
        chk("locked", locked, e.locked);
        chk("onehot", int'(eq) + int'(gt) + int'(lt), 1);
`ifdef COMPARADOR_MATCH_COUNT_EN
        chk("match_count", match_count, e.cnt);
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fi", fi, 0);
    chk("rst_eq", eq, 0);
    chk("rst_locked", locked, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic equal compare, latency 1
    cycle(1, 5, 5, 0, 1, 0);
    chk("lat_out_valid", out_valid, 1);
    chk("lat_fi", fi, 1);
    chk("lat_eq", eq, 1);
    cycle(0, 0, 0, 0, 1, 0);
    chk("drain_out_valid", out_valid, 0);

    // Backpressure: result held, next pair not accepted
    cycle(1, 6, 2, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 7, 2, 0, 0);
      chk("hold_fi", fi, 1);
      chk("hold_gt", gt, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    cycle(1, 1, 7, 2, 1, 0);
    chk("bp_second_lt", lt, 1);
    cycle(0, 0, 0, 0, 1, 0);

    // Lock run then break
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 3, 3, 0, 1, 0);
    chk("lock_after4", locked, 1);
    cycle(1, 3, 4, 0, 1, 0);
    chk("lock_broken", locked, 0);
    chk("break_fi", fi, 0);

    // Clear coincident with fourth passing transfer
    for (int i = 0; i < 3; i++) cycle(1, 2, 2, 0, 1, 0);
    cycle(1, 2, 2, 0, 1, 1);
    chk("clr_locked", locked, 0);
    chk("clr_fi", fi, 1);
`ifdef COMPARADOR_MATCH_COUNT_EN
    chk("clr_count", match_count, 0);
    for (int i = 0; i < 5; i++) cycle(1, 4, 1, 1, 1, 0);
    chk("sat_count", match_count, CMAX);
`endif

    // Asynchronous reset while holding a locked result
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 1, 6, 3, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_locked", locked, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_fi", fi, 0);
    chk("arst_gt", gt, 0);
    chk("arst_lt", lt, 0);
    chk("arst_locked", locked, 0);
    chk("arst_in_ready", in_ready, 1);
    q.delete(); m_run = 0; m_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Random traffic, clear only with a transfer
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(3, 0) != 0, $urandom_range(7, 0), $urandom_range(7, 0),
            $urandom_range(3, 0), $urandom_range(9, 0) < 7, $urandom_range(9, 0) == 0);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0);
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
